// File: rtl/seletor_entrada.sv
// Input stage for the Comparador: three debounced buttons select i in 1..11,
// ok confirms the value with a timed valid strobe, then waits for full release.
module seletor_entrada #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_ok,
    output logic [3:0] i,
    output logic       v,
    output logic [1:0] estado
);

    localparam int DW = $clog2(DEB_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        SELEC  = 2'b00,
        CONF   = 2'b01,
        ESPERA = 2'b10
    } state_t;

    // Bit order everywhere: [0] up, [1] down, [2] ok.
    logic [2:0]    raw;
    logic [2:0]    deb;
    logic [2:0]    deb_prev;
    logic [2:0]    press;
    logic [DW-1:0] deb_cnt [3];

    state_t        state, state_next;
    logic [3:0]    i_next;
    logic [HW-1:0] hold_cnt, hold_next;

    assign raw   = {btn_ok, btn_down, btn_up};
    assign press = deb & ~deb_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            deb      <= '0;
            deb_prev <= '0;
            for (int k = 0; k < 3; k++) begin
                deb_cnt[k] <= '0;
            end
        end else begin
            deb_prev <= deb;
            for (int k = 0; k < 3; k++) begin
                if (raw[k] == deb[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DW'(DEB_CYCLES - 1)) begin
                    deb[k]     <= ~deb[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SELEC;
            i        <= 4'd1;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            i        <= i_next;
            hold_cnt <= hold_next;
        end
    end

    always_comb begin
        state_next = state;
        i_next     = i;
        hold_next  = hold_cnt;
        case (state)
            SELEC: begin
                if (press[2]) begin
                    state_next = CONF;
                    hold_next  = HW'(HOLD_CYCLES);
                end else if (press[0] && !press[1]) begin
                    i_next = (i == 4'd11) ? 4'd1 : i + 4'd1;
                end else if (press[1] && !press[0]) begin
                    i_next = (i == 4'd1) ? 4'd11 : i - 4'd1;
                end
            end
            CONF: begin
                // Leaving on the count of 1 gives exactly HOLD_CYCLES cycles in CONF.
                if (hold_cnt <= HW'(1)) begin
                    state_next = ESPERA;
                    hold_next  = '0;
                end else begin
                    hold_next = hold_cnt - 1'b1;
                end
            end
            ESPERA: begin
                if (deb == 3'b000) begin
                    state_next = SELEC;
                end
            end
            default: state_next = SELEC;
        endcase
        if (i == 4'd0 || i > 4'd11) begin
            i_next = 4'd1;
        end
    end

    always_comb begin
        v      = (state == CONF);
        estado = state;
    end

endmodule

// File: tb/tb_seletor_entrada.sv
// Bench for seletor_entrada: cycle-level behavioural model compared every cycle,
// plus directed button sequences with literal expectations.
module tb_seletor_entrada;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_ok = 1'b0;
    logic [3:0] i;
    logic       v;
    logic [1:0] estado;

    int tests = 0;
    int fails = 0;

    seletor_entrada #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_ok   (btn_ok),
        .i        (i),
        .v        (v),
        .estado   (estado)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_up(input int high, input int low);
        btn_up = 1'b1;
        tick(high);
        btn_up = 1'b0;
        tick(low);
    endtask

    task automatic pulse_down(input int high, input int low);
        btn_down = 1'b1;
        tick(high);
        btn_down = 1'b0;
        tick(low);
    endtask

    // Behavioural model: mode 0 selecting, 1 confirmed, 2 waiting for release.
    int m_i, m_mode, m_hold;
    int m_deb[3], m_run[3], m_prev[3], m_raw[3], m_ev[3];
    bit model_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_i    = 1;
            m_mode = 0;
            m_hold = 0;
            for (int k = 0; k < 3; k++) begin
                m_deb[k]  = 0;
                m_run[k]  = 0;
                m_prev[k] = 0;
            end
            model_ok = 1'b1;
        end else if (model_ok) begin
            m_raw[0] = int'(btn_up);
            m_raw[1] = int'(btn_down);
            m_raw[2] = int'(btn_ok);
            for (int k = 0; k < 3; k++) begin
                m_ev[k] = (m_deb[k] == 1 && m_prev[k] == 0) ? 1 : 0;
            end
            case (m_mode)
                0: begin
                    if (m_ev[2] == 1) begin
                        m_mode = 1;
                        m_hold = HOLD;
                    end else if (m_ev[0] == 1 && m_ev[1] == 0) begin
                        m_i = m_i % 11 + 1;
                    end else if (m_ev[1] == 1 && m_ev[0] == 0) begin
                        m_i = (m_i + 9) % 11 + 1;
                    end
                end
                1: begin
                    m_hold = m_hold - 1;
                    if (m_hold == 0) m_mode = 2;
                end
                default: begin
                    if (m_deb[0] + m_deb[1] + m_deb[2] == 0) m_mode = 0;
                end
            endcase
            for (int k = 0; k < 3; k++) begin
                m_prev[k] = m_deb[k];
                if (m_raw[k] != m_deb[k]) begin
                    m_run[k] = m_run[k] + 1;
                    if (m_run[k] == DEB) begin
                        m_deb[k] = 1 - m_deb[k];
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("cyc_i", int'(i), m_i);
            check("cyc_v", int'(v), (m_mode == 1) ? 1 : 0);
            check("cyc_estado", int'(estado), m_mode);
        end
    end

    initial begin
        int vcount;

        // Reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("rst_i", int'(i), 1);
        check("rst_v", int'(v), 0);
        check("rst_estado", int'(estado), 0);

        // Up presses with wrap; each change lands on the 5th edge after the rise
        for (int k = 1; k <= 11; k++) begin
            btn_up = 1'b1;
            tick(4);
            check("up_before", int'(i), k);
            tick(1);
            check("up_after", int'(i), (k == 11) ? 1 : k + 1);
            tick(1);
            btn_up = 1'b0;
            tick(6);
        end

        // Down with wrap
        pulse_down(6, 6);
        check("down_wrap", int'(i), 11);
        for (int k = 0; k < 3; k++) pulse_down(6, 6);
        check("down_three", int'(i), 8);

        // Short pulses and chatter are rejected
        pulse_up(1, 6);
        pulse_up(2, 6);
        pulse_up(3, 6);
        pulse_up(3, 1);
        pulse_up(3, 6);
        check("glitch_i", int'(i), 8);
        pulse_up(4, 6);
        check("deb4_i", int'(i), 9);
        pulse_down(6, 6);
        pulse_down(6, 6);
        check("pre_conf_i", int'(i), 7);

        // Confirm with ok held 30 cycles; up presses during CONF and ESPERA
        vcount = 0;
        btn_ok = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            if (n == 7 || n == 18) btn_up = 1'b1;
            if (n == 13 || n == 24) btn_up = 1'b0;
            @(negedge clk);
            if (n == 4) check("conf_v_pre", int'(v), 0);
            if (n == 5) check("conf_v_rise", int'(v), 1);
            if (n == 13) check("conf_v_fall", int'(v), 0);
            if (v) begin
                vcount++;
                check("conf_i", int'(i), 7);
                check("conf_estado", int'(estado), 1);
            end
        end
        check("conf_vcount", vcount, HOLD);
        check("espera_estado", int'(estado), 2);
        check("espera_i", int'(i), 7);
        btn_ok = 1'b0;
        tick(4);
        check("espera_hold", int'(estado), 2);
        tick(2);
        check("selec_back", int'(estado), 0);
        check("selec_i", int'(i), 7);

        // Reset in the middle of CONF
        btn_ok = 1'b1;
        tick(7);
        check("mid_conf_v", int'(v), 1);
        rst = 1'b1;
        btn_ok = 1'b0;
        tick(1);
        rst = 1'b0;
        check("rst_conf_v", int'(v), 0);
        check("rst_conf_i", int'(i), 1);
        check("rst_conf_estado", int'(estado), 0);
        tick(6);

        // Up and down together: no change
        btn_up = 1'b1;
        btn_down = 1'b1;
        tick(6);
        btn_up = 1'b0;
        btn_down = 1'b0;
        tick(6);
        check("updown_i", int'(i), 1);

        // Up and ok together: ok wins, i unchanged
        btn_up = 1'b1;
        btn_ok = 1'b1;
        tick(5);
        check("upok_v", int'(v), 1);
        check("upok_i", int'(i), 1);
        check("upok_estado", int'(estado), 1);
        btn_up = 1'b0;
        btn_ok = 1'b0;
        tick(10);
        check("upok_end_estado", int'(estado), 0);
        check("upok_end_i", int'(i), 1);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
